instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Front end of the 4-bit CPU that supplies the instruction register.
- Holds the program counter and reads 8-bit instructions from program memory over a req/valid handshake.
- Delivers each byte on instruction_out with a one-cycle ir_load_en strobe, which is the IR's load input.
- Waits for the control unit's exec_done before advancing the PC (sequential or jump), and stops on the HALT opcode.

Parameters:
- ADDR_W, 4: program counter and memory address width; PC wraps modulo 2^ADDR_W.
- HALT_OP, 4'b1111: opcode (instruction bits [7:4]) that stops fetching.
- FETCH_TIMEOUT, 15: maximum cycles spent in FETCH waiting for mem_valid before faulting; range 1..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin or restart fetching; honoured only in IDLE or HALTED.
- mem_req  output  1  read request to program memory.
- mem_addr  output  ADDR_W  read address; equals pc while mem_req=1.
- mem_valid  input  1  read data valid; honoured only in FETCH.
- mem_rdata  input  8  instruction byte from memory.
- ir_load_en  output  1  one-cycle load strobe to the instruction register.
- instruction_out  output  8  fetched instruction byte to the instruction register.
- exec_done  input  1  current instruction finished executing; honoured only in EXEC.
- jump_en  input  1  sampled with exec_done; 1 selects jump_addr as next PC.
- jump_addr  input  ADDR_W  jump target.
- pc  output  ADDR_W  current program counter.
- busy  output  1  high in FETCH, LOAD, EXEC.
- halted  output  1  high in HALTED.
- fault  output  1  memory timeout occurred; sticky until restart or reset.

Behaviour:
- Reset: clk and reset are fixed as above (one clock, synchronous active-low reset). When reset=0 at a rising edge:
  - state=IDLE;
  - pc, mem_addr, instruction_out = 0; timeout counter = 0;
  - mem_req, ir_load_en, busy, halted, fault = 0.
  - Reset overrides every other input and aborts any state, including mid-FETCH with mem_req high.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, EXEC, HALTED.
- IDLE:
  - start=1 → FETCH.
  - mem_req=1 and mem_addr=pc from the next cycle.
- FETCH:
  - mem_req=1; mem_addr=pc, held stable.
  - Timeout counter is cleared on entry and increments each FETCH cycle without mem_valid.
  - mem_valid=1 → capture mem_rdata into instruction_out; mem_req=0 from the next cycle; → LOAD.
  - Counter reaching FETCH_TIMEOUT without mem_valid → mem_req=0, fault=1, → HALTED.
  - mem_valid on the timeout cycle wins: the data is captured, no fault.
- LOAD:
  - ir_load_en=1 for exactly this one cycle; instruction_out is stable here and remains stable until the next capture.
  - instruction_out[7:4]==HALT_OP → HALTED. pc is not incremented and keeps the HALT instruction's address.
  - Otherwise → EXEC.
- EXEC:
  - Wait for exec_done. While waiting, pc and instruction_out hold.
  - On exec_done=1: pc ← jump_en ? jump_addr : pc+1 (ADDR_W-bit wrap, so all-ones+1=0); → FETCH with the new pc on mem_addr the next cycle.
  - A jump to the current pc is legal (tight loop).
- HALTED:
  - halted=1; start=1 → pc=0, fault=0, → FETCH.
  - start has no effect in FETCH, LOAD or EXEC; exec_done and jump_en are ignored outside EXEC; mem_valid is ignored outside FETCH.
- Latency (zero-wait memory):
  - start sampled at edge N → mem_req visible after edge N.
  - mem_valid sampled at edge M → ir_load_en high for the cycle after M.
  - exec_done at edge K → next mem_req with the updated address after K.
  - Minimum of 3 cycles per instruction (FETCH, LOAD, EXEC).

Test Plan:
- Reset then start=1; memory returns 8'h25 at addr 0 with zero wait; exec_done one cycle after ir_load_en → ir_load_en high exactly 1 cycle, instruction_out=8'h25, pc=1, next mem_addr=1.
- Memory adds 3 wait cycles on every read → mem_req and mem_addr held for 4 cycles, a single ir_load_en per instruction, no fault.
- At pc=3, exec_done with jump_en=1 and jump_addr=4'hA → next mem_addr=4'hA. Separately, pc=4'hF with sequential exec_done → next mem_addr=0 (wrap).
- Byte 8'hF0 at addr 2 → ir_load_en pulses, then halted=1, busy=0, pc=2. A subsequent start → pc=0, fetching resumes.
- mem_valid held low with FETCH_TIMEOUT=15 → after 15 FETCH cycles mem_req=0, fault=1, halted=1. start → fault=0, pc=0.
- reset=0 asserted mid-FETCH and mid-EXEC → at the next edge all outputs return to their reset values, state=IDLE; spurious exec_done or mem_valid in IDLE has no effect.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the 4-bit CPU.
// Holds the PC, fetches bytes over a req/valid handshake, strobes them into the IR,
// waits for execution to finish, then advances or jumps. Stops on the HALT opcode or
// on a memory read timeout.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W        = 4,
  parameter logic [3:0]  HALT_OP       = 4'b1111,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [7:0]        mem_rdata,
  output logic              ir_load_en,
  output logic [7:0]        instruction_out,
  input  logic              exec_done,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_HALTED
  } state_t;

  // Last counter value still allowed to wait; one more empty cycle faults.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [7:0]        instr_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic              fault_d;
  logic              req_d, load_d, busy_d, halted_d;

  // Next-state, next-PC, capture and timeout logic; outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    instr_d = instruction_out;
    tcnt_d  = tcnt_q;
    fault_d = fault;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tcnt_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (mem_valid) begin
          instr_d = mem_rdata;
          state_d = S_LOAD;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      S_LOAD: begin
        if (instruction_out[7:4] == HALT_OP) state_d = S_HALTED;
        else                                 state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          pc_d    = jump_en ? jump_addr : pc + ADDR_W'(1);
          tcnt_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          fault_d = 1'b0;
          tcnt_d  = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d    = (state_d == S_FETCH);
    load_d   = (state_d == S_LOAD);
    busy_d   = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALTED);
  end

  // State register and registered outputs; mem_addr tracks the PC so it is valid whenever mem_req is.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      pc              <= '0;
      mem_addr        <= '0;
      instruction_out <= '0;
      tcnt_q          <= '0;
      mem_req         <= 1'b0;
      ir_load_en      <= 1'b0;
      busy            <= 1'b0;
      halted          <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc              <= pc_d;
      mem_addr        <= pc_d;
      instruction_out <= instr_d;
      tcnt_q          <= tcnt_d;
      mem_req         <= req_d;
      ir_load_en      <= load_d;
      busy            <= busy_d;
      halted          <= halted_d;
      fault           <= fault_d;
    end
  end

endmodule
